// File: rtl/cdb_wb_arbiter.sv
// Round-robin arbiter sharing the commit_rename writeback port among N_FU functional units.
// One registered output stage. A flush drops the held packet. Saturating conflict counter.
//
// out_v | meaning
// 0     | output stage empty; can accept a grant
// 1     | packet held on wb_pkt; a grant is allowed only when wb_ready drains it
module cdb_wb_arbiter #(
  parameter int  N_FU    = 3,
  parameter int  N_FU_W  = $clog2(N_FU),
  parameter int  CNT_W   = 16,
  parameter type fu_wb_t = logic [31:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_FU-1:0]       fu_valid,
  output logic [N_FU-1:0]       fu_ready,
  input  fu_wb_t [N_FU-1:0]     fu_pkt,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output fu_wb_t                wb_pkt,
  input  logic                  flush_valid,
  output logic [N_FU_W-1:0]     grant_idx,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic              out_v;
  fu_wb_t            out_pkt;
  logic [N_FU_W-1:0] rr_ptr;
  logic [N_FU_W-1:0] win;
  logic [N_FU_W-1:0] cand;
  logic              grant;
  logic              can_load;
  int                idx;

  // rst_n is folded in so no FU sees a handshake while reset is held
  assign can_load = rst_n && (!out_v || wb_ready) && !flush_valid;

  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_FU) idx = idx - N_FU;
      cand = N_FU_W'(idx);
      if (can_load && !grant && fu_valid[cand]) begin
        grant = 1'b1;
        win   = cand;
      end
    end
  end

  assign fu_ready  = grant ? (N_FU'(1) << win) : '0;
  assign grant_idx = win;
  assign wb_valid  = out_v;
  assign wb_pkt    = out_pkt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v        <= 1'b0;
      out_pkt      <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (flush_valid) begin
        out_v <= 1'b0;
      end else if (grant) begin
        out_v   <= 1'b1;
        out_pkt <= fu_pkt[win];
        rr_ptr  <= (win == N_FU_W'(N_FU - 1)) ? '0 : win + N_FU_W'(1);
      end else if (wb_ready) begin
        out_v <= 1'b0;
      end
      if (grant && ($countones(fu_valid) >= 2) && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model of the writeback arbiter.
module tb_cdb_wb_arbiter;

  localparam int N    = 3;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      fu_valid;
  logic [N-1:0]      fu_ready;
  logic [N-1:0][31:0] fu_pkt;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_pkt;
  logic              flush_valid;
  logic [1:0]        grant_idx;
  logic [CW-1:0]     conflict_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_out_v;
  logic [31:0] m_pkt;
  int          m_rr;
  int          m_cnt;
  int          last_win;

  always #5 clk = ~clk;

  cdb_wb_arbiter #(.N_FU(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_pkt(fu_pkt),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pkt(wb_pkt),
    .flush_valid(flush_valid), .grant_idx(grant_idx), .conflict_cnt(conflict_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_win();
    int i;
    if (flush_valid || (m_out_v && !wb_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (fu_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_out_v = 0; m_pkt = '0; m_rr = 0; m_cnt = 0; last_win = -1;
  endtask

  // one clock: compare at negedge, advance model at posedge, return 1 time unit later
  task automatic step();
    int w;
    logic [N-1:0] er;
    @(negedge clk);
    w  = model_win();
    er = (w >= 0) ? (N'(1) << w) : '0;
    check("fu_ready", fu_ready, er);
    if (w >= 0) check("grant_idx", grant_idx, w);
    check("wb_valid", wb_valid, m_out_v);
    if (m_out_v) check("wb_pkt", wb_pkt, m_pkt);
    check("conflict_cnt", conflict_cnt, m_cnt);
    @(posedge clk);
    if (flush_valid) m_out_v = 0;
    else if (w >= 0) begin
      m_out_v = 1;
      m_pkt   = fu_pkt[w];
      m_rr    = (w + 1) % N;
      if ($countones(fu_valid) >= 2 && m_cnt < CMAX) m_cnt++;
    end else if (wb_ready) m_out_v = 0;
    last_win = w;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fu_valid = '0; wb_ready = 1'b0; flush_valid = 1'b0; fu_pkt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; fu_valid = '1; wb_ready = 1'b1; flush_valid = 1'b0; fu_pkt = '0;
    #1;
    check("rst_fu_ready", fu_ready, 3'b000);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_pkt", wb_pkt, 32'h0);
    check("rst_cnt", conflict_cnt, 4'd0);

    // single requester
    apply_reset();
    fu_valid = 3'b010; fu_pkt[1] = 32'hA1; wb_ready = 1'b1;
    #1;
    check("t1_ready", fu_ready, 3'b010);
    check("t1_idx", grant_idx, 2'd1);
    step();
    fu_valid = '0;
    check("t1_wbv", wb_valid, 1'b1);
    check("t1_pkt", wb_pkt, 32'hA1);
    fu_valid = 3'b111;
    #1 check("t1_rr", grant_idx, 2'd2);
    fu_valid = '0;
    step();

    // round-robin wrap, then counter saturation at 15
    apply_reset();
    wb_ready = 1'b1; fu_valid = 3'b111;
    for (int i = 0; i < N; i++) fu_pkt[i] = 32'h200 + i;
    for (int g = 0; g < 20; g++) begin
      #1 check("t2_idx", grant_idx, g % 3);
      step();
      fu_pkt[g % 3] = fu_pkt[g % 3] + 32'h10;
      if (g == 5) check("t2_cnt6", conflict_cnt, 4'd6);
    end
    check("t5_sat", conflict_cnt, 4'd15);

    // backpressure: held packet stable, no grants, resume without bubble
    wb_ready = 1'b0;
    repeat (4) begin
      #1 check("t3_stall_ready", fu_ready, 3'b000);
      step();
    end
    check("t3_hold", wb_pkt, 32'h261);
    wb_ready = 1'b1;
    #1 check("t3_resume", fu_ready, 3'b100);
    step();
    check("t3_nobubble", wb_valid, 1'b1);

    // flush drops held packet; FU2 granted once afterwards
    apply_reset();
    wb_ready = 1'b1; fu_valid = 3'b001; fu_pkt[0] = 32'h300;
    step();
    fu_valid = 3'b100; fu_pkt[2] = 32'h3C2; flush_valid = 1'b1;
    #1 check("t4_flush_ready", fu_ready, 3'b000);
    step();
    flush_valid = 1'b0;
    check("t4_drop", wb_valid, 1'b0);
    #1 check("t4_regrant", fu_ready, 3'b100);
    step();
    fu_valid = '0;
    check("t4_wbv", wb_valid, 1'b1);
    check("t4_pkt", wb_pkt, 32'h3C2);
    step();
    check("t4_nodup", wb_valid, 1'b0);

    // asynchronous reset during a stall
    wb_ready = 1'b0; fu_valid = 3'b010; fu_pkt[1] = 32'h4A1;
    step();
    fu_valid = 3'b111;
    step();
    check("t6_pre", wb_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", wb_valid, 1'b0);
    check("t6_ready_rst", fu_ready, 3'b000);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1; wb_ready = 1'b1;
    #1 check("t6_rr", grant_idx, 2'd0);
    step();

    // randomized traffic; FUs hold valid/pkt until their transfer
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wb_ready    = ($urandom_range(0, 3) != 0);
      flush_valid = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        if (!fu_valid[i] && ($urandom_range(0, 1) == 1)) begin
          fu_valid[i] = 1'b1;
          fu_pkt[i]   = $urandom;
        end
      step();
      if (last_win >= 0) fu_valid[last_win] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
